m_umem_arbiter: RTL and testbench

Arbiter that shares one single-port synchronous word RAM (1-cycle registered read, write-on-clock, same behaviour as the processor's instruction/data memories) between the pipeline's IF fetch port and its MEM load/store port. Enables a unified instruction+data memory. Emits per-port grant/stall and read-valid signals to the pipeline. Includes a starvation guard so sustained load/store traffic cannot lock out fetch indefinitely.

---
 rtl/m_umem_arbiter.sv | 129 ++++++++++++
 tb/tb_m_umem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_umem_arbiter.sv
// m_umem_arbiter: shares one single-port synchronous word RAM between the
// IF fetch port and the MEM load/store port. MEM wins conflicts unless IF
// has lost STARVE_MAX consecutive arbitrations, in which case IF is forced.
// Optional build macro: ARB_PERF_CNT_EN (conflict / forced-win counters).
module m_umem_arbiter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_i_req,
  input  logic [AW-1:0] w_i_addr,
  input  logic          w_i_flush,
  output logic          w_i_gnt,
  output logic          w_i_vld,
  output logic [DW-1:0] w_i_rdata,
  input  logic          w_d_req,
  input  logic          w_d_we,
  input  logic [AW-1:0] w_d_addr,
  input  logic [DW-1:0] w_d_wdata,
  output logic          w_d_gnt,
  output logic          w_d_vld,
  output logic [DW-1:0] w_d_rdata,
  output logic [AW-1:0] w_m_addr,
  output logic          w_m_we,
  output logic [DW-1:0] w_m_din,
  input  logic [DW-1:0] w_m_dout,
  output logic [31:0]   r_conf_cnt,
  output logic [31:0]   r_frc_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_ME   = 2'd2
  } own_t;

  own_t          r_own;
  own_t          own_nxt;
  logic [3:0]    r_starve;
  logic          r_iflush;
  logic [DW-1:0] r_i_hold;
  logic [DW-1:0] r_d_hold;
  logic          starve_win;

  // Per-cycle arbitration and RAM port mux.
  always_comb begin
    starve_win = w_i_req & w_d_req & (r_starve == 4'(STARVE_MAX));
    w_i_gnt    = w_i_req & (~w_d_req | starve_win);
    w_d_gnt    = w_d_req & ~w_i_gnt;
    w_m_addr   = '0;
    if (w_i_gnt)      w_m_addr = w_i_addr;
    else if (w_d_gnt) w_m_addr = w_d_addr;
    w_m_we     = w_d_gnt & w_d_we;
    w_m_din    = w_d_wdata;
  end

  // Response owner for the read data arriving next cycle.
  always_comb begin
    own_nxt = OWN_NONE;
    if (w_i_gnt)                  own_nxt = OWN_IF;
    else if (w_d_gnt & ~w_d_we)   own_nxt = OWN_ME;
  end

  // Response owner register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_own <= OWN_NONE;
    else          r_own <= own_nxt;
  end

  // Starvation counter: counts consecutive lost IF arbitrations, saturating.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_starve <= '0;
    end else if (w_i_req & ~w_i_gnt) begin
      if (r_starve != 4'(STARVE_MAX)) r_starve <= r_starve + 4'd1;
    end else begin
      r_starve <= '0;
    end
  end

  // Registered flush so a flush raised in the grant cycle cancels the response.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_iflush <= 1'b0;
    else          r_iflush <= w_i_flush;
  end

  // Valid generation: the registered flush covers a flush in the grant cycle,
  // the live flush covers one raised in the response cycle itself.
  always_comb begin
    w_i_vld = (r_own == OWN_IF) & ~r_iflush & ~w_i_flush;
    w_d_vld = (r_own == OWN_ME);
  end

  // Read data hold registers keep the last response stable.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (w_i_vld) r_i_hold <= w_m_dout;
      if (w_d_vld) r_d_hold <= w_m_dout;
    end
  end

  // Read data select: live RAM data on the valid cycle, held data otherwise.
  always_comb begin
    w_i_rdata = w_i_vld ? w_m_dout : r_i_hold;
    w_d_rdata = w_d_vld ? w_m_dout : r_d_hold;
  end

`ifdef ARB_PERF_CNT_EN
  // Performance counters: conflict cycles and starvation-forced IF wins.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_conf_cnt <= '0;
      r_frc_cnt  <= '0;
    end else begin
      if (w_i_req & w_d_req) r_conf_cnt <= r_conf_cnt + 32'd1;
      if (starve_win)        r_frc_cnt  <= r_frc_cnt + 32'd1;
    end
  end
`else
  assign r_conf_cnt = '0;
  assign r_frc_cnt  = '0;
`endif

endmodule

// File: tb/tb_m_umem_arbiter.sv
// Self-checking bench for m_umem_arbiter: directed vector table, hand-written
// starvation/reset sequences, and randomized traffic against a reference model.
module tb_m_umem_arbiter;

  localparam int SMAX = 4;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        w_i_req, w_i_flush, w_i_gnt, w_i_vld;
  logic [11:0] w_i_addr;
  logic [31:0] w_i_rdata;
  logic        w_d_req, w_d_we, w_d_gnt, w_d_vld;
  logic [11:0] w_d_addr;
  logic [31:0] w_d_wdata, w_d_rdata;
  logic [11:0] w_m_addr;
  logic        w_m_we;
  logic [31:0] w_m_din, w_m_dout;
  logic [31:0] r_conf_cnt, r_frc_cnt;

  m_umem_arbiter #(.AW(12), .DW(32), .STARVE_MAX(SMAX)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_i_req(w_i_req), .w_i_addr(w_i_addr), .w_i_flush(w_i_flush),
    .w_i_gnt(w_i_gnt), .w_i_vld(w_i_vld), .w_i_rdata(w_i_rdata),
    .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr),
    .w_d_wdata(w_d_wdata), .w_d_gnt(w_d_gnt), .w_d_vld(w_d_vld),
    .w_d_rdata(w_d_rdata), .w_m_addr(w_m_addr), .w_m_we(w_m_we),
    .w_m_din(w_m_din), .w_m_dout(w_m_dout),
    .r_conf_cnt(r_conf_cnt), .r_frc_cnt(r_frc_cnt)
  );

  always #5 w_clk = ~w_clk;

  // Single-port synchronous RAM attached to the arbiter.
  logic [31:0] mem [4096];
  always @(posedge w_clk) begin
    if (w_m_we) mem[w_m_addr] <= w_m_din;
    w_m_dout <= mem[w_m_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] ref_mem [4096];
  int          m_starve;
  int          m_pend;      // 0 none, 1 IF read outstanding, 2 MEM read outstanding
  bit          m_pflush;
  logic [31:0] m_pdata, m_ihold, m_dhold, m_conf, m_frc;

  task automatic model_reset();
    m_starve = 0; m_pend = 0; m_pflush = 0; m_pdata = '0;
    m_ihold = '0; m_dhold = '0; m_conf = '0; m_frc = '0;
  endtask

  task automatic mexp(output bit iw, output bit dw, output bit iv, output bit dv);
    iw = w_i_req && (!w_d_req || m_starve >= SMAX);
    dw = w_d_req && !iw;
    iv = (m_pend == 1) && !m_pflush && !w_i_flush;
    dv = (m_pend == 2);
  endtask

  task automatic mcheck();
    bit iw, dw, iv, dv;
    logic [11:0] ea;
    mexp(iw, dw, iv, dv);
    ea = iw ? w_i_addr : (dw ? w_d_addr : 12'd0);
    chk("i_gnt", 32'(w_i_gnt), 32'(iw));
    chk("d_gnt", 32'(w_d_gnt), 32'(dw));
    chk("m_addr", 32'(w_m_addr), 32'(ea));
    chk("m_we", 32'(w_m_we), 32'(dw && w_d_we));
    chk("m_din", w_m_din, w_d_wdata);
    chk("i_vld", 32'(w_i_vld), 32'(iv));
    chk("d_vld", 32'(w_d_vld), 32'(dv));
    chk("i_rdata", w_i_rdata, iv ? m_pdata : m_ihold);
    chk("d_rdata", w_d_rdata, dv ? m_pdata : m_dhold);
    chk("conf_cnt", r_conf_cnt, m_conf);
    chk("frc_cnt", r_frc_cnt, m_frc);
  endtask

  task automatic mupdate();
    bit iw, dw, iv, dv;
    mexp(iw, dw, iv, dv);
    if (iv) m_ihold = m_pdata;
    if (dv) m_dhold = m_pdata;
`ifdef ARB_PERF_CNT_EN
    if (w_i_req && w_d_req) m_conf = m_conf + 32'd1;
    if (iw && w_d_req)      m_frc  = m_frc + 32'd1;
`endif
    if (iw) begin
      m_pend = 1; m_pdata = ref_mem[w_i_addr];
    end else if (dw && !w_d_we) begin
      m_pend = 2; m_pdata = ref_mem[w_d_addr];
    end else begin
      m_pend = 0;
    end
    if (dw && w_d_we) ref_mem[w_d_addr] = w_d_wdata;
    if (w_i_req && !iw) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    else                m_starve = 0;
    m_pflush = w_i_flush;
    if (!w_rst_n) model_reset();
  endtask

  task automatic drive(input bit ir, input logic [11:0] ia, input bit fl,
                       input bit dr, input bit we, input logic [11:0] da,
                       input logic [31:0] wd);
    w_i_req = ir; w_i_addr = ia; w_i_flush = fl;
    w_d_req = dr; w_d_we = we; w_d_addr = da; w_d_wdata = wd;
  endtask

  task automatic pre();  #3; mcheck(); endtask
  task automatic post(); @(posedge w_clk); mupdate(); #1; endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 w_rst_n = 1'b0;
    model_reset();
    #1 mcheck();
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
  endtask

  typedef struct {
    bit ir; logic [11:0] ia; bit fl;
    bit dr; bit we; logic [11:0] da; logic [31:0] wd;
    bit eig, edg, eiv, edv;
    logic [31:0] eir, edr;
  } vec_t;

  function automatic vec_t mk(bit ir, logic [11:0] ia, bit fl, bit dr, bit we,
                              logic [11:0] da, logic [31:0] wd, bit eig, bit edg,
                              bit eiv, bit edv, logic [31:0] eir, logic [31:0] edr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.we = we; v.da = da; v.wd = wd;
    v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[5] = 32'h2014000B; ref_mem[5] = 32'h2014000B;
    w_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge w_clk); @(posedge w_clk); #1;
    w_rst_n = 1'b1;

    // Directed vectors: IF read, hold, write-then-read, flushed fetch.
    tbl[0]  = mk(1, 12'd5,    0, 0, 0, 0,      0,        1, 0, 0, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 0,        0, 0, 0, 0,      0,        0, 0, 1, 0, 32'h2014000B, 32'h0);
    tbl[2]  = mk(0, 0,        0, 0, 0, 0,      0,        0, 0, 0, 0, 32'h2014000B, 32'h0);
    tbl[3]  = mk(0, 0,        0, 1, 1, 12'h40, 32'hABCD, 0, 1, 0, 0, 32'h2014000B, 32'h0);
    tbl[4]  = mk(0, 0,        0, 1, 0, 12'h40, 0,        0, 1, 0, 0, 32'h2014000B, 32'h0);
    tbl[5]  = mk(0, 0,        0, 0, 0, 0,      0,        0, 0, 0, 1, 32'h2014000B, 32'hABCD);
    tbl[6]  = mk(1, 12'd8,    0, 0, 0, 0,      0,        1, 0, 0, 0, 32'h2014000B, 32'hABCD);
    tbl[7]  = mk(0, 0,        1, 0, 0, 0,      0,        0, 0, 0, 0, 32'h2014000B, 32'hABCD);
    tbl[8]  = mk(0, 0,        0, 0, 0, 0,      0,        0, 0, 0, 0, 32'h2014000B, 32'hABCD);
    tbl[9]  = mk(1, 12'd8,    0, 1, 0, 12'h40, 0,        0, 1, 0, 0, 32'h2014000B, 32'hABCD);
    tbl[10] = mk(0, 0,        0, 0, 0, 0,      0,        0, 0, 0, 1, 32'h2014000B, 32'hABCD);
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].ir, tbl[k].ia, tbl[k].fl, tbl[k].dr, tbl[k].we, tbl[k].da, tbl[k].wd);
      pre();
      chk($sformatf("tbl%0d i_gnt", k), 32'(w_i_gnt), 32'(tbl[k].eig));
      chk($sformatf("tbl%0d d_gnt", k), 32'(w_d_gnt), 32'(tbl[k].edg));
      chk($sformatf("tbl%0d i_vld", k), 32'(w_i_vld), 32'(tbl[k].eiv));
      chk($sformatf("tbl%0d d_vld", k), 32'(w_d_vld), 32'(tbl[k].edv));
      chk($sformatf("tbl%0d i_rdata", k), w_i_rdata, tbl[k].eir);
      chk($sformatf("tbl%0d d_rdata", k), w_d_rdata, tbl[k].edr);
      post();
    end

    // Sustained conflict: MEM wins four times, IF forced on the fifth.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, 12'(k), 0, 1, 0, 12'(100 + k), 0);
      pre();
      chk($sformatf("starve i_gnt c%0d", k), 32'(w_i_gnt), 32'((k % 5) == 4));
      post();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    pre();
`ifdef ARB_PERF_CNT_EN
    chk("conf_cnt after 10", r_conf_cnt, 32'd10);
    chk("frc_cnt after 10", r_frc_cnt, 32'd2);
`else
    chk("conf_cnt tied", r_conf_cnt, 32'd0);
    chk("frc_cnt tied", r_frc_cnt, 32'd0);
`endif
    post();

    // IF loses 3 times, drops req once: starvation count restarts from zero.
    for (int k = 0; k < 3; k++) begin
      drive(1, 12'd3, 0, 1, 0, 12'd7, 0);
      pre(); chk("lose d_gnt", 32'(w_d_gnt), 32'd1); post();
    end
    drive(0, 0, 0, 1, 0, 12'd7, 0);
    pre(); post();
    for (int k = 0; k < 5; k++) begin
      drive(1, 12'd3, 0, 1, 0, 12'd7, 0);
      pre(); chk($sformatf("restart i_gnt c%0d", k), 32'(w_i_gnt), 32'(k == 4)); post();
    end

    // Reset pulsed in the cycle after an IF grant.
    drive(1, 12'd5, 0, 0, 0, 0, 0);
    pre(); post();
    drive(1, 12'd5, 0, 1, 0, 12'd9, 0);
    #2 w_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst i_vld", 32'(w_i_vld), 32'd0);
    chk("rst i_rdata", w_i_rdata, 32'd0);
    chk("rst conf_cnt", r_conf_cnt, 32'd0);
    chk("rst frc_cnt", r_frc_cnt, 32'd0);
    chk("rst d_gnt follows req", 32'(w_d_gnt), 32'd1);
    mcheck();
    @(posedge w_clk); mupdate(); #1;
    w_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 12'd5, 0, 1, 0, 12'd9, 0);
      pre(); chk($sformatf("post-rst i_gnt c%0d", k), 32'(w_i_gnt), 32'(k == 4)); post();
    end

    // Randomized traffic over a small address window.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), 12'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), 12'($urandom_range(0, 15)), $urandom);
      pre(); post();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
